// File: rtl/vx_prng_gen.sv
// rtl/vx_prng_gen.sv - multi-channel Galois LFSR random source with shared reseed/warmup engine
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   out_valid    [NUM_CH]           per-channel random value available
//   out_ready    [NUM_CH]           per-channel consumer accepts value (advances that channel)
//   out_data     [NUM_CH*OUT_BITS]  channel c at bits [c*OUT_BITS +: OUT_BITS]
//   seed_valid   reseed request
//   seed_ready   reseed request can be accepted (IDLE and not in reset)
//   seed_ch      target channel of the reseed
//   seed_data    new seed value (zero is mapped to 1)

module vx_prng_gen #(
    parameter int                NUM_CH   = 4,
    parameter int                WIDTH    = 32,
    parameter int                OUT_BITS = 8,
    parameter logic [WIDTH-1:0]  TAPS     = 32'h80200003,
    parameter logic [WIDTH-1:0]  SEED     = 32'hACE12468,
    parameter int                WARMUP   = 4,
    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*OUT_BITS-1:0]   out_data,
    input  logic                         seed_valid,
    output logic                         seed_ready,
    input  logic [CH_W-1:0]              seed_ch,
    input  logic [WIDTH-1:0]             seed_data
);

    localparam logic [7:0]    CNT_LAST  = 8'(WARMUP - 1);
    localparam logic [CH_W:0] NUM_CH_V  = (CH_W + 1)'(NUM_CH);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_WARMUP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        cnt;
    logic [CH_W-1:0]   target;
    logic [WIDTH-1:0]  s [NUM_CH];
    logic              accept;
    logic              load;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    // Zero is a lock-up state for the LFSR, so it is replaced with 1.
    function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // Channels are decorrelated by xoring in a golden-ratio multiple of the
    // channel index; the product is taken modulo 2^32 and then resized.
    function automatic logic [WIDTH-1:0] reset_seed(input int c);
        logic [31:0] mix;
        mix = c * 32'h9E3779B9;
        return nonzero(SEED ^ WIDTH'(mix));
    endfunction

    assign seed_ready = (state == ST_IDLE) && !reset;
    assign accept     = seed_valid && seed_ready;
    // Out-of-range channel requests are consumed but change nothing.
    assign load       = accept && ({1'b0, seed_ch} < NUM_CH_V);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_valid[c] = !reset && !((state == ST_WARMUP) && (target == CH_W'(c)));
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_out
            assign out_data[gc*OUT_BITS +: OUT_BITS] = s[gc][OUT_BITS-1:0];
        end
    endgenerate

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load && (WARMUP != 0)) begin
                    state_next = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            target <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                s[c] <= reset_seed(c);
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    s[c] <= advance(s[c]);
                end
            end
            // Later assignment wins: a reseed overrides a same-edge pop.
            if (load) begin
                s[seed_ch] <= nonzero(seed_data);
                cnt        <= '0;
                target     <= seed_ch;
            end else if (state == ST_WARMUP) begin
                s[target] <= advance(s[target]);
                cnt       <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/vx_prng_gen.md
VX_PRNG_GEN -- requirements
Module: vx_prng_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent generator channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, LFSR state width per channel (8..64).
REQ-003 SHALL have parameter OUT_BITS, default 8, random bits presented per channel (1..WIDTH).
REQ-004 SHALL have parameter TAPS, default 32'h80200003, Galois feedback mask (WIDTH bits).
REQ-005 SHALL have parameter SEED, default 32'hACE12468, base seed (WIDTH bits).
REQ-006 SHALL have parameter WARMUP, default 4, LFSR advances after a reseed before output is re-enabled (0..255).
REQ-007 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port out_valid, output, NUM_CH, per-channel random value available.
REQ-010 SHALL have port out_ready, input, NUM_CH, per-channel consumer accepts value.
REQ-011 SHALL have port out_data, output, NUM_CH*OUT_BITS, channel c at bits [c*OUT_BITS +: OUT_BITS].
REQ-012 SHALL have port seed_valid, input, 1, reseed request.
REQ-013 SHALL have port seed_ready, output, 1, reseed request can be accepted.
REQ-014 SHALL have port seed_ch, input, $clog2(NUM_CH) (min 1), target channel.
REQ-015 SHALL have port seed_data, input, WIDTH, new seed value.

Function
REQ-016 SHALL keep per-channel WIDTH-bit state s[c]; advance = (s>>1) ^ (s[0] ? TAPS : 0).
REQ-017 SHALL drive out_data for channel c as s[c][OUT_BITS-1:0], combinationally from state.
REQ-018 SHALL advance s[c] exactly once on each edge where out_valid[c] & out_ready[c]; otherwise hold (IDLE).
REQ-019 SHALL implement a single shared reseed FSM, states IDLE, WARMUP.
REQ-020 SHALL drive seed_ready = 1 only in IDLE and not in reset.
REQ-021 SHALL accept reseed on seed_valid & seed_ready; on that edge s[seed_ch] <= (seed_data==0 ? 1 : seed_data), counter <= 0, FSM -> WARMUP (or stays IDLE if WARMUP==0).
REQ-022 SHALL, in WARMUP, advance s[target] once per edge and increment counter; on the edge where counter==WARMUP-1, FSM -> IDLE.
REQ-023 SHALL hold out_valid[target]=0 from the cycle after acceptance until FSM returns to IDLE; other channels unaffected.
REQ-024 SHALL give reseed priority over a handshake on the same channel in the same edge (the pop is dropped, not advanced).
REQ-025 SHALL accept but ignore a reseed whose seed_ch >= NUM_CH (no state change, FSM stays IDLE).
REQ-026 SHALL never hold an all-zero state; zero seed maps to 1, and the nonzero TAPS keeps state nonzero.
REQ-027 SHALL allow all channels to handshake simultaneously in one cycle, each advancing independently.

Reset
REQ-028 SHALL on reset load s[c] = SEED ^ (c * 32'h9E3779B9 truncated/zero-extended to WIDTH), replacing 0 with 1.
REQ-029 SHALL hold out_valid=0 and seed_ready=0 while reset is high; FSM IDLE, counter 0.
REQ-030 SHALL assert out_valid all-ones and seed_ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL let reset abort a WARMUP in progress; all channels reload reset seeds.

Verification
REQ-032 Default params, reset release -> out_data ch0=8'h68, ch1=8'hD1 (state 32'h32D65DD1), out_valid=4'hF.
REQ-033 ch0 out_ready held 1 for two edges -> ch0 out_data 8'h68, 8'h34, 8'h1A; other channels unchanged.
REQ-034 seed_valid, seed_ch=2, seed_data=0 accepted at cycle T -> out_valid[2]=0 for T+1..T+4, seed_ready=0 T+1..T+4, at T+5 state 32'hB02C0003, out_data ch2=8'h03.
REQ-035 Reseed ch0 with seed_data=32'h12345678 while out_ready[0]=1 same edge -> state 32'h12345678 then warmup from it; pop dropped.
REQ-036 seed_valid held during WARMUP -> seed_ready=0, no second acceptance until IDLE; reset asserted mid-WARMUP -> reset seeds restored, outputs per REQ-030.
REQ-037 Random out_ready on all channels 10k cycles -> each channel sequence matches reference Galois model, never zero state.
